// File: rtl/ram_dp_pkg.sv
// Shared types and constants for the dual-port RAM with post-reset clear sweep.
package ram_dp_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  // Same-address, same-cycle double write: port A's data is kept.
  localparam bit PORT_A_WINS = 1'b1;

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/ram_dp_mem_if.sv
// Request/response bundle between a system-side master and the dual-port RAM.
interface ram_dp_mem_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          w_a;
  logic [AW-1:0] a_a;
  logic [DW-1:0] d_a;
  logic [DW-1:0] q_a;
  logic          w_b;
  logic [AW-1:0] a_b;
  logic [DW-1:0] d_b;
  logic [DW-1:0] q_b;
  logic          init_busy;

  modport master (
    output w_a, a_a, d_a, w_b, a_b, d_b,
    input  q_a, q_b, init_busy
  );

  modport slave (
    input  w_a, a_a, d_a, w_b, a_b, d_b,
    output q_a, q_b, init_busy
  );
endinterface

// File: rtl/ram_dp_clr_seq.sv
// INIT/READY sequencer: walks clr_cnt over every word after reset, then idles in READY.
// state | meaning
// INIT  | clear sweep running, one word written per cycle while rst is low
// READY | normal dual-port operation until the next reset
module ram_dp_clr_seq
  import ram_dp_pkg::*;
#(
  parameter int AW             = 16,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  output logic          init_busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  // One extra counter bit keeps the terminal compare from aliasing with zero.
  localparam logic [AW:0] LAST_ADDR = (AW+1)'(depth_of(AW) - 1);

  state_t      state_q, state_d;
  logic [AW:0] clr_cnt_q, clr_cnt_d;
  logic        busy_q, busy_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      if (CLEAR_ON_RESET) state_q <= INIT;
      else                state_q <= READY;
      clr_cnt_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == INIT) begin
      clr_cnt_d = clr_cnt_q + (AW+1)'(1);
      if (clr_cnt_q == LAST_ADDR) state_d = READY;
    end
    busy_d = (state_d == INIT);
  end

  always_comb begin
    init_busy = busy_q;
    clr_we    = (state_q == INIT) && !rst;
    clr_addr  = clr_cnt_q[AW-1:0];
  end

endmodule

// File: rtl/ram_dp_mem.sv
// True dual-port synchronous-read RAM with write-first ports, cross-port bypass
// and a post-reset clear sweep that borrows the port A write path.
module ram_dp_mem
  import ram_dp_pkg::*;
#(
  parameter int            AW             = 16,
  parameter int            DW             = 16,
  parameter bit            CLEAR_ON_RESET = 1'b1,
  parameter logic [DW-1:0] INIT_VAL       = '0
) (
  input  logic      clk,
  input  logic      rst,
  ram_dp_mem_if.slave bus
);

  localparam int DEPTH = depth_of(AW);

  logic [DW-1:0] mem [DEPTH];

  logic          init_busy;
  logic          clr_we;
  logic [AW-1:0] clr_addr;

  logic          same_addr;
  logic          we_a, we_b;
  logic [AW-1:0] wa_addr;
  logic [DW-1:0] wa_data;
  logic [DW-1:0] q_a_d, q_a_q;
  logic [DW-1:0] q_b_d, q_b_q;

  ram_dp_clr_seq #(
    .AW             (AW),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clr_seq (
    .clk       (clk),
    .rst       (rst),
    .init_busy (init_busy),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr)
  );

  always_comb begin
    same_addr = (bus.a_a == bus.a_b);
    we_a      = 1'b0;
    we_b      = 1'b0;
    wa_addr   = bus.a_a;
    wa_data   = bus.d_a;
    q_a_d     = '0;
    q_b_d     = '0;
    if (init_busy) begin
      we_a    = clr_we;
      wa_addr = clr_addr;
      wa_data = INIT_VAL;
    end else begin
      we_a = bus.w_a;
      we_b = bus.w_b;
      if (bus.w_a && bus.w_b && same_addr) begin
        if (PORT_A_WINS) we_b = 1'b0;
        else             we_a = 1'b0;
      end
      // Reads see this cycle's write from either port rather than the stale word.
      q_a_d = we_a ? bus.d_a : ((we_b && same_addr) ? bus.d_b : mem[bus.a_a]);
      q_b_d = we_b ? bus.d_b : ((we_a && same_addr) ? bus.d_a : mem[bus.a_b]);
    end
  end

  always_ff @(posedge clk) begin
    if (we_a) mem[wa_addr] <= wa_data;
    if (we_b) mem[bus.a_b] <= bus.d_b;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_a_q <= '0;
      q_b_q <= '0;
    end else begin
      q_a_q <= q_a_d;
      q_b_q <= q_b_d;
    end
  end

  assign bus.q_a       = q_a_q;
  assign bus.q_b       = q_b_q;
  assign bus.init_busy = init_busy;

endmodule

// File: tb/tb_ram_dp_mem.sv
// Directed bench for ram_dp_mem: clear sweep, R/W, bypass, collision, reset mid-sweep.
module tb_ram_dp_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0 = 1'b1;
  logic rst1 = 1'b1;
  logic rst2 = 1'b1;

  ram_dp_mem_if #(.AW(4), .DW(16)) bus0 ();
  ram_dp_mem_if #(.AW(4), .DW(16)) bus1 ();
  ram_dp_mem_if #(.AW(4), .DW(16)) bus2 ();

  ram_dp_mem #(.AW(4), .DW(16), .CLEAR_ON_RESET(1'b1), .INIT_VAL(16'h0000))
    dut0 (.clk(clk), .rst(rst0), .bus(bus0));
  ram_dp_mem #(.AW(4), .DW(16), .CLEAR_ON_RESET(1'b1), .INIT_VAL(16'hFFFF))
    dut1 (.clk(clk), .rst(rst1), .bus(bus1));
  ram_dp_mem #(.AW(4), .DW(16), .CLEAR_ON_RESET(1'b0), .INIT_VAL(16'hFFFF))
    dut2 (.clk(clk), .rst(rst2), .bus(bus2));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        w_a;
    logic [3:0]  a_a;
    logic [15:0] d_a;
    logic        w_b;
    logic [3:0]  a_b;
    logic [15:0] d_b;
    logic [15:0] eq_a;
    logic [15:0] eq_b;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic busy_of(input int k);
    case (k)
      0:       return bus0.init_busy;
      1:       return bus1.init_busy;
      default: return bus2.init_busy;
    endcase
  endfunction

  task automatic count_busy(input int k, output int n);
    n = 0;
    while (busy_of(k) && n < 40) begin
      n++;
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    {bus0.w_a, bus0.a_a, bus0.d_a, bus0.w_b, bus0.a_b, bus0.d_b} = '0;
    {bus1.w_a, bus1.a_a, bus1.d_a, bus1.w_b, bus1.a_b, bus1.d_b} = '0;
    {bus2.w_a, bus2.a_a, bus2.d_a, bus2.w_b, bus2.a_b, bus2.d_b} = '0;

    //          w_a a_a d_a       w_b a_b d_b       q_a       q_b
    vecs[0]  = '{1'b1, 4'd3,  16'hBEEF, 1'b0, 4'd9,  16'h0000, 16'hBEEF, 16'h0000};
    vecs[1]  = '{1'b0, 4'd1,  16'h0000, 1'b0, 4'd3,  16'h0000, 16'h0000, 16'hBEEF};
    vecs[2]  = '{1'b1, 4'd7,  16'h1234, 1'b0, 4'd7,  16'h0000, 16'h1234, 16'h1234};
    vecs[3]  = '{1'b0, 4'd7,  16'h0000, 1'b0, 4'd7,  16'h0000, 16'h1234, 16'h1234};
    vecs[4]  = '{1'b1, 4'd5,  16'hAAAA, 1'b1, 4'd5,  16'h5555, 16'hAAAA, 16'hAAAA};
    vecs[5]  = '{1'b0, 4'd5,  16'h0000, 1'b0, 4'd5,  16'h0000, 16'hAAAA, 16'hAAAA};
    vecs[6]  = '{1'b0, 4'd8,  16'h0000, 1'b1, 4'd8,  16'h0F0F, 16'h0F0F, 16'h0F0F};
    vecs[7]  = '{1'b1, 4'd1,  16'h1111, 1'b1, 4'd2,  16'h2222, 16'h1111, 16'h2222};
    vecs[8]  = '{1'b0, 4'd2,  16'h0000, 1'b0, 4'd1,  16'h0000, 16'h2222, 16'h1111};
    vecs[9]  = '{1'b0, 4'd15, 16'h0000, 1'b0, 4'd0,  16'h0000, 16'h0000, 16'h0000};
    vecs[10] = '{1'b1, 4'd0,  16'h7777, 1'b1, 4'd15, 16'hC3C3, 16'h7777, 16'hC3C3};
    vecs[11] = '{1'b0, 4'd15, 16'h0000, 1'b0, 4'd0,  16'h0000, 16'hC3C3, 16'h7777};
    vecs[12] = '{1'b0, 4'd3,  16'h0000, 1'b0, 4'd8,  16'h0000, 16'hBEEF, 16'h0F0F};

    // dut0: reset state, requests held during reset and sweep must be dropped
    bus0.w_a = 1'b1; bus0.a_a = 4'd0; bus0.d_a = 16'h9999;
    bus0.w_b = 1'b1; bus0.a_b = 4'd1; bus0.d_b = 16'h8888;
    tick();
    tick();
    check("rst_q_a", bus0.q_a, 16'h0000);
    check("rst_q_b", bus0.q_b, 16'h0000);
    check("rst_busy", bus0.init_busy, 1'b1);
    rst0 = 1'b0;
    count_busy(0, n);
    check("sweep_len", n, 16);
    check("sweep_q_a_held", bus0.q_a, 16'h0000);
    check("sweep_q_b_held", bus0.q_b, 16'h0000);
    bus0.w_a = 1'b0;
    bus0.w_b = 1'b0;

    for (int i = 0; i < 16; i++) begin
      bus0.a_a = 4'(i);
      bus0.a_b = 4'(15 - i);
      tick();
      check($sformatf("clr_a@%0d", i), bus0.q_a, 16'h0000);
      check($sformatf("clr_b@%0d", 15 - i), bus0.q_b, 16'h0000);
    end

    for (int i = 0; i < 13; i++) begin
      bus0.w_a = vecs[i].w_a; bus0.a_a = vecs[i].a_a; bus0.d_a = vecs[i].d_a;
      bus0.w_b = vecs[i].w_b; bus0.a_b = vecs[i].a_b; bus0.d_b = vecs[i].d_b;
      tick();
      check($sformatf("vec%0d_q_a", i), bus0.q_a, vecs[i].eq_a);
      check($sformatf("vec%0d_q_b", i), bus0.q_b, vecs[i].eq_b);
    end
    bus0.w_a = 1'b0;
    bus0.w_b = 1'b0;

    // dut2: no sweep, busy drops on the first edge after release
    tick();
    check("noclr_rst_busy", bus2.init_busy, 1'b1);
    rst2 = 1'b0;
    check("noclr_busy_pre_edge", bus2.init_busy, 1'b1);
    tick();
    check("noclr_busy_post_edge", bus2.init_busy, 1'b0);
    bus2.w_a = 1'b1; bus2.a_a = 4'd2; bus2.d_a = 16'h0042; bus2.a_b = 4'd2;
    tick();
    check("noclr_q_a", bus2.q_a, 16'h0042);
    check("noclr_q_b_bypass", bus2.q_b, 16'h0042);
    bus2.w_a = 1'b0;
    tick();
    check("noclr_q_b_read", bus2.q_b, 16'h0042);

    // dut1: preload, then reset mid-sweep and confirm the sweep restarts
    rst1 = 1'b0;
    count_busy(1, n);
    check("ff_sweep_len", n, 16);
    bus1.w_a = 1'b1; bus1.a_a = 4'd2; bus1.d_a = 16'h0042;
    tick();
    bus1.w_a = 1'b0;
    tick();
    check("ff_preload", bus1.q_a, 16'h0042);
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    repeat (8) tick();
    check("ff_busy_mid", bus1.init_busy, 1'b1);
    rst1 = 1'b1;
    tick();
    tick();
    check("ff_busy_in_rst", bus1.init_busy, 1'b1);
    check("ff_q_a_in_rst", bus1.q_a, 16'h0000);
    rst1 = 1'b0;
    count_busy(1, n);
    check("ff_restart_len", n, 16);
    bus1.a_a = 4'd2;
    bus1.a_b = 4'd15;
    tick();
    check("ff_q_a@2", bus1.q_a, 16'hFFFF);
    check("ff_q_b@15", bus1.q_b, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_dp_mem.md
Name: ram_dp_mem

Overview:
- Memory-side (responder) end of the dual-port RAM interface: a true dual-port, synchronous-read RAM that serves two independent requesters, A and B.
- Adds a post-reset clear sweep, so contents are defined before first use.
- Sits beneath any system-side master that drives w/a/d and consumes q.
- Single clock domain: both ports run on one clock.

Parameters:
- AW, 16, address width; depth = 2**AW words.
- DW, 16, data word width.
- CLEAR_ON_RESET, 1, 1 = sweep all words to INIT_VAL after reset; 0 = skip the sweep, contents undefined.
- INIT_VAL, '0, DW-bit value written by the clear sweep.

Ports:
- clk  input  1  single clock for both ports.
- rst  input  1  synchronous, active-high reset.
- w_a  input  1  port A write enable.
- a_a  input  AW  port A address.
- d_a  input  DW  port A write data.
- q_a  output  DW  port A read data, registered.
- w_b  input  1  port B write enable.
- a_b  input  AW  port B address.
- d_b  input  DW  port B write data.
- q_b  output  DW  port B read data, registered.
- init_busy  output  1  high while reset or the clear sweep is in progress; port requests are ignored while high.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: q_a=0, q_b=0, init_busy=1, state=INIT (CLEAR_ON_RESET=1) or READY (CLEAR_ON_RESET=0), clr_cnt=0.
- Reset affects control and output registers only. It does not touch array contents, except through the sweep.
- States:
  - INIT: while rst=0, each cycle writes INIT_VAL to mem[clr_cnt] and increments clr_cnt.
  - INIT -> READY on the edge that writes address 2**AW-1. init_busy falls on that same edge.
  - The sweep therefore takes exactly 2**AW cycles after rst is released.
  - READY: normal operation. There is no exit except rst.
- CLEAR_ON_RESET=0: init_busy=1 only while rst is high. It drops on the first edge with rst=0.
- While init_busy=1:
  - w_a/w_b are dropped and reads are not performed.
  - q_a/q_b hold 0.
- Reset asserted mid-sweep: clr_cnt returns to 0 and the sweep restarts from address 0 after release.
- Read latency is 1 cycle. q_x is updated on every READY edge; there is no read enable.
- Same-port write: write-first. If w_x=1, then q_x = d_x on the next cycle.
- Cross-port, same address, one writer: the reader sees the new data. Example: w_a=1, w_b=0, a_a==a_b gives q_b = d_a. This is a bypass, not the stale word.
- Both ports write the same address: port A wins. mem=d_a, q_a=d_a, q_b=d_a. d_b is discarded.
- Different addresses: the two ports are fully independent, with full throughput on both every cycle.
- Address wrap: none. Every AW-bit address is valid.
- Clear counter: AW+1 bits internally, so the terminal compare does not alias.

Decomposition:
- Package ram_dp_pkg:
  - state typedef {INIT, READY}.
  - Collision policy constant, PORT_A_WINS.
  - Localparam helper for depth.
- Optional sub-module ram_dp_clr_seq: the INIT/READY FSM plus clr_cnt. It outputs init_busy, clr_we and clr_addr, which mux onto the port A write path.
- The array, the bypass logic and the output registers stay in ram_dp_mem.

Test Plan (AW=4, DW=16, INIT_VAL=16'h0000 unless stated):
- Clear sweep: pulse rst 2 cycles, then release.
  - init_busy stays 1 for exactly 16 cycles after release.
  - Afterwards, reading every address on both ports returns 16'h0000.
- Basic R/W: A writes 16'hBEEF@3, then B reads @3.
  - q_a=16'hBEEF one cycle after the write (write-first).
  - q_b=16'hBEEF one cycle after the B read.
- Read bypass: A writes 16'h1234@7 while B reads @7 in the same cycle.
  - q_b=16'h1234 next cycle.
  - A later B read @7 returns 16'h1234.
- Write collision: A writes 16'hAAAA@5 and B writes 16'h5555@5 in the same cycle.
  - q_a=q_b=16'hAAAA.
  - A subsequent read @5 returns 16'hAAAA.
- Reset mid-sweep with INIT_VAL=16'hFFFF:
  - Preload @2=16'h0042 (CLEAR_ON_RESET=0 run), then switch to CLEAR_ON_RESET=1.
  - Assert rst at sweep cycle 8.
  - Sweep restarts; init_busy stays high 16 cycles after the final release.
  - @2 reads 16'hFFFF.
- Requests ignored during init: drive w_a=1 d_a=16'h9999@0 while init_busy=1.
  - q_a stays 0.
  - After READY, @0 reads INIT_VAL.
